// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the serial add/subtract unit: op codes, FSM states,
// and a helper that sizes the digit counter.
package addsub_serial_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold 0..n-1; a single-digit build still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_serial_digit_adder.sv
// DIGIT-wide ripple-carry slice built from single-bit full adders; the serial
// unit feeds it one digit of each operand per clock.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] A,
    input  logic [DIGIT-1:0] B,
    input  logic             Cin,
    output logic [DIGIT-1:0] Y,
    output logic             Cout
);
    logic [DIGIT:0] chain;

    assign chain[0] = Cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        full_adder u_fa (
            .a    (A[gi]),
            .b    (B[gi]),
            .cin  (chain[gi]),
            .s    (Y[gi]),
            .cout (chain[gi+1])
        );
    end

    assign Cout = chain[DIGIT];
endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement add/subtract, DIGIT bits per clock, with a
// valid/ready handshake and carry/ovf/zero flags. Saturation via ADDSUB_SAT_EN.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             sat
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
        $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             op_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] y_reg;
    logic             flag_carry_reg;
    logic             flag_ovf_reg;
    logic             flag_zero_reg;
    logic             flag_sat_reg;
    logic             out_valid_reg;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] y_next;
    logic             ovf_next;
    logic             sat_next;
    logic             last_digit;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .A    (a_reg[DIGIT-1:0]),
        .B    (b_reg[DIGIT-1:0]),
        .Cin  (carry_reg),
        .Y    (slice_sum),
        .Cout (slice_cout)
    );

    // Each new digit enters at the top so the LSB digit ends up at bit 0
    // after N shifts; the wide concatenation also covers the N==1 case.
    logic [WIDTH+DIGIT-1:0] sum_concat;
    assign sum_concat = {slice_sum, sum_reg};
    assign sum_next   = sum_concat[WIDTH+DIGIT-1:DIGIT];
    assign last_digit = (cnt_reg == CW'(N - 1));

    always_comb begin
        ovf_next = (a_msb_reg == b_msb_reg) && (sum_next[WIDTH-1] != a_msb_reg);
        y_next   = sum_next;
        sat_next = 1'b0;
`ifdef ADDSUB_SAT_EN
        if (ovf_next) begin
            y_next   = a_msb_reg ? MIN_NEG : MAX_POS;
            sat_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            sum_reg        <= '0;
            carry_reg      <= 1'b0;
            op_reg         <= 1'b0;
            a_msb_reg      <= 1'b0;
            b_msb_reg      <= 1'b0;
            cnt_reg        <= '0;
            y_reg          <= '0;
            flag_carry_reg <= 1'b0;
            flag_ovf_reg   <= 1'b0;
            flag_zero_reg  <= 1'b0;
            flag_sat_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with op.
                        a_reg     <= A;
                        b_reg     <= (op == OP_SUB) ? ~B : B;
                        carry_reg <= op;
                        op_reg    <= op;
                        a_msb_reg <= A[WIDTH-1];
                        b_msb_reg <= (op == OP_SUB) ? ~B[WIDTH-1] : B[WIDTH-1];
                        sum_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    sum_reg   <= sum_next;
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_digit) begin
                        y_reg          <= y_next;
                        flag_carry_reg <= slice_cout ^ op_reg;
                        flag_ovf_reg   <= ovf_next;
                        flag_zero_reg  <= (y_next == '0);
                        flag_sat_reg   <= sat_next;
                        out_valid_reg  <= 1'b1;
                        state_reg      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE) && !reset;
    assign out_valid = out_valid_reg;
    assign Y         = y_reg;
    assign carry     = flag_carry_reg;
    assign ovf       = flag_ovf_reg;
    assign zero      = flag_zero_reg;
    assign sat       = flag_sat_reg;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed and random operations against
// an arithmetic reference model, plus a DIGIT==WIDTH instance.
module tb_addsub_serial;
    localparam int W  = 8;
    localparam int D  = 2;
    localparam int NC = W / D;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, op, out_valid, out_ready;
    logic [W-1:0] a_in, b_in, y_out;
    logic carry, ovf, zero, sat;

    logic w_in_valid, w_in_ready, w_op, w_out_valid, w_out_ready;
    logic [15:0] w_a, w_b, w_y;
    logic w_carry, w_ovf, w_zero, w_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(a_in), .B(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .Y(y_out), .carry(carry), .ovf(ovf), .zero(zero), .sat(sat)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(16)) dut_wide (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .op(w_op), .A(w_a), .B(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .Y(w_y), .carry(w_carry), .ovf(w_ovf), .zero(w_zero), .sat(w_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] y, output logic c, output logic v,
                         output logic z, output logic s);
        int ua, ub, sa, sb, ru, rs;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ru = o ? ua - ub : ua + ub;
        rs = o ? sa - sb : sa + sb;
        y  = W'(ru & ((1 << W) - 1));
        c  = o ? (ua < ub) : (ru >= (1 << W));
        v  = (rs > (1 << (W - 1)) - 1) || (rs < -(1 << (W - 1)));
        s  = 1'b0;
`ifdef ADDSUB_SAT_EN
        if (v) begin
            y = (rs > 0) ? W'((1 << (W - 1)) - 1) : W'(1 << (W - 1));
            s = 1'b1;
        end
`endif
        z = (y == '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, measure latency, check result; optionally release it.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit release_it);
        logic [W-1:0] ey;
        logic ec, ev, ez, es;
        int w, lat;
        model(o, a, b, ey, ec, ev, ez, es);
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        op = o; a_in = a; b_in = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        op = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        $display("op=%0d A=%02h B=%02h -> Y=%02h c=%0d v=%0d z=%0d s=%0d lat=%0d (exp Y=%02h)",
                 o, a, b, y_out, carry, ovf, zero, sat, lat, ey);
        check("latency", lat, NC);
        check("Y", y_out, ey);
        check("carry", {31'b0, carry}, {31'b0, ec});
        check("ovf", {31'b0, ovf}, {31'b0, ev});
        check("zero", {31'b0, zero}, {31'b0, ez});
        check("sat", {31'b0, sat}, {31'b0, es});
        if (release_it) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("out_valid_drop", {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] hy;
        logic hc, hv, hz;
        int lat;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0;
        a_in = '0; b_in = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_op = 1'b0; w_a = '0; w_b = '0;
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_Y", y_out, 32'd0);
        check("rst_flags", {28'b0, carry, ovf, zero, sat}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        run_op(1'b1, 8'h05, 8'h03, 1'b1);
        run_op(1'b1, 8'h03, 8'h05, 1'b1);
        run_op(1'b1, 8'h44, 8'h00, 1'b1);
        run_op(1'b0, 8'h80, 8'h80, 1'b1);
        run_op(1'b0, 8'h7F, 8'h01, 1'b0);

        // Hold the result: outputs frozen, new request ignored.
        hy = y_out; hc = carry; hv = ovf; hz = zero;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1; op = 1'b1; a_in = 8'h11; b_in = 8'h22;
            end
            step();
            in_valid = 1'b0;
            check("hold_Y", y_out, hy);
            check("hold_flags", {29'b0, carry, ovf, zero}, {29'b0, hc, hv, hz});
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        $display("hold: Y=%02h held for 5 cycles", y_out);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_release", {31'b0, out_valid}, 32'd0);
        check("in_ready_after_release", {31'b0, in_ready}, 32'd1);

        // Abort mid-RUN with reset.
        op = 1'b0; a_in = 8'h33; b_in = 8'h44; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_Y", y_out, 32'd0);
        check("abort_flags", {28'b0, carry, ovf, zero, sat}, 32'd0);
        reset = 1'b0;
        $display("reset mid-run: Y=%02h out_valid=%0d", y_out, out_valid);
        for (int i = 0; i < NC + 2; i++) begin
            step();
            check("abort_no_result", {31'b0, out_valid}, 32'd0);
        end
        run_op(1'b0, 8'h10, 8'h20, 1'b1);

        for (int i = 0; i < 24; i++) begin
            run_op($urandom_range(0, 1), W'($urandom), W'($urandom), 1'b1);
        end

        // DIGIT == WIDTH: single RUN cycle.
        w_op = 1'b1; w_a = 16'h1234; w_b = 16'h1234; w_in_valid = 1'b1;
        check("wide_in_ready", {31'b0, w_in_ready}, 32'd1);
        step();
        w_in_valid = 1'b0;
        w_a = 16'hFFFF; w_b = 16'h0001;
        lat = 0;
        while (!w_out_valid && lat < 50) begin
            step();
            lat++;
        end
        $display("wide op=1 A=1234 B=1234 -> Y=%04h c=%0d z=%0d lat=%0d", w_y, w_carry, w_zero, lat);
        check("wide_latency", lat, 32'd1);
        check("wide_Y", w_y, 32'h0000);
        check("wide_zero", {31'b0, w_zero}, 32'd1);
        check("wide_carry", {31'b0, w_carry}, 32'd0);
        check("wide_ovf", {31'b0, w_ovf}, 32'd0);
        w_out_ready = 1'b1;
        step();
        w_out_ready = 1'b0;
        check("wide_release", {31'b0, w_out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle two's-complement add/subtract unit.
- Processes DIGIT bits per clock through a DIGIT-bit ripple full-adder slice, with a registered carry between digits.
- Successor to the fixed 8-bit combinational subtractor: adds width generality, an add/sub mode, status flags and a valid/ready handshake.
- Sits between the operand registers and the display/result path of the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle (1..WIDTH); N = WIDTH/DIGIT is the number of compute cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  unit can accept operands.
- op  input  1  0 = A+B, 1 = A-B.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- Y  output  WIDTH  result, registered.
- carry  output  1  add: carry-out; sub: borrow (A<B unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  Y == 0.
- sat  output  1  saturation applied (only with ADDSUB_SAT_EN; otherwise tied 0).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, Y=0, carry=0, ovf=0, zero=0, sat=0, out_valid=0, digit counter=0.
- in_ready = (state==IDLE) && !reset, combinational.
- States: IDLE, RUN, DONE.
- IDLE: on in_valid && in_ready, capture:
  - A into the A shift register.
  - B (inverted when op=1) into the B shift register.
  - carry_reg = op.
  - MSBs of A and of the effective B operand.
  - Then go to RUN with counter=0.
- RUN, each cycle:
  - Add the low DIGIT bits of the A/B shift registers plus carry_reg.
  - Shift the sum into the result register from the top; shift A/B right by DIGIT.
  - carry_reg <= slice carry-out; counter++.
- Last RUN cycle (counter==N-1): go to DONE and set out_valid=1. Flags are computed from the final sum:
  - carry = carry-out XOR op.
  - ovf = (Amsb==Beff_msb) && (Ymsb != Amsb).
  - zero = (final Y == 0).
- Latency: operands accepted at edge t; out_valid rises at edge t+N. Throughput is one operation per N+2 cycles.
- DONE:
  - Y and flags are held stable while out_valid && !out_ready.
  - On out_ready, out_valid goes to 0 next edge and the state returns to IDLE. Y and flags keep their last value until the next result.
- in_valid outside IDLE is ignored; operands are not queued.
- A and B may change freely after acceptance without affecting the result.
- Reset asserted in any state aborts the operation: all outputs take reset values on that edge and partial results are discarded.
- Wrap-around without saturation: results are modulo 2^WIDTH.
  - A-B with A<B yields the two's-complement difference with carry=1.
  - B=0 in subtract yields carry=0.
- DIGIT==WIDTH is legal: N=1, and a single RUN cycle completes the operation.
- A WIDTH that is not a multiple of DIGIT is an elaboration error.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - On ovf=1, Y clamps to 0111..1 when Amsb=0, or 1000..0 when Amsb=1.
  - sat=1 with that result.
  - zero is evaluated on the clamped Y.
  - carry and ovf still report the raw condition.
- Undefined: Y wraps; the sat port exists but is driven 0.

Decomposition:
- Shared package:
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - State encoding IDLE/RUN/DONE (2-bit).
  - A clog2-based counter-width helper.
- Sub-module: digit_adder, a DIGIT-wide ripple of the existing full_adder cells.
  - Ports: A[DIGIT], B[DIGIT], Cin, Y[DIGIT], Cout.
  - Instantiated once.

Test Plan (WIDTH=8, DIGIT=2, N=4 unless noted):
- op=SUB, A=0x05, B=0x03 -> Y=0x02, carry=0, ovf=0, zero=0; out_valid exactly 4 cycles after acceptance.
- op=SUB, A=0x03, B=0x05 -> Y=0xFE, carry=1, ovf=0.
- op=ADD, A=0x7F, B=0x01 -> Y=0x80, ovf=1, carry=0; with ADDSUB_SAT_EN: Y=0x7F, sat=1.
- op=ADD, A=0x80, B=0x80 -> Y=0x00, carry=1, zero=1, ovf=1; with ADDSUB_SAT_EN: Y=0x80, zero=0, sat=1.
- Hold and reset behaviour:
  - Hold out_ready=0 for 5 cycles: Y and flags stay stable, in_ready=0, and an in_valid pulse is ignored.
  - Then assert reset mid-RUN on a following op: out_valid=0, Y=0 on the next edge.
  - The next op, ADD 0x10+0x20, gives Y=0x30.
- WIDTH=16, DIGIT=16: SUB 0x1234-0x1234 -> Y=0x0000, zero=1, carry=0, latency 1 cycle.
